// File: rtl/stream_predelay_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stream_predelay_mc
//  Purpose  : Multichannel predelay stage for the reverb audio path. Every
//             accepted frame is written into a circular buffer. The frame
//             written predelay frames earlier is then read back and sent
//             downstream. Delay changes take effect between frames. Outputs
//             are zero until the buffer holds enough history. A dry bypass
//             is also provided.
//  Ports    : clk_clk         - system clock
//             reset_reset     - asynchronous, active-high reset
//             sink_*          - input frame stream (data/valid/ready)
//             source_*        - delayed frame stream (data/valid/ready)
//             predelay_value  - requested delay in frames
//             predelay_update - single-cycle strobe capturing predelay_value
//             bypass          - pass the input frame straight through
//  Revision : 1.0 - initial release
// ============================================================================
module stream_predelay_mc #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [NUM_CH*DATA_W-1:0] sink_data,
  input  logic                     sink_valid,
  output logic                     sink_ready,
  output logic [NUM_CH*DATA_W-1:0] source_data,
  output logic                     source_valid,
  input  logic                     source_ready,
  input  logic [ADDR_W-1:0]        predelay_value,
  input  logic                     predelay_update,
  input  logic                     bypass
);

  localparam int FW    = NUM_CH * DATA_W;
  localparam int DEPTH = 1 << ADDR_W;

  // fill saturates at the buffer depth, so it needs one extra bit
  localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [FW-1:0]     r_mem [DEPTH];
  logic [FW-1:0]     r_ram_q;
  logic [FW-1:0]     r_in_frame;
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_delay_active;
  logic [ADDR_W-1:0] r_delay_pending;
  logic [ADDR_W:0]   r_fill;
  logic              r_pend_flag;
  logic              r_sel;
  logic              r_zero;

  logic              w_accept;
  logic [ADDR_W-1:0] w_rd_addr;

  // Ready is masked by reset so that it reads 0 while reset is held,
  // even though the state register already sits in IDLE.
  assign sink_ready = (r_state == S_IDLE) && !reset_reset;
  assign w_accept   = sink_valid && sink_ready;
  assign w_rd_addr  = r_wr_ptr - r_delay_active;

  // The buffer is not reset. Stale contents are hidden by the fill check.
  // At delay 0 the read address equals the write address. That case is
  // always served from the captured input frame, so the read-during-write
  // result is never used.
  always_ff @(posedge clk_clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= sink_data;
      r_ram_q         <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state         <= S_IDLE;
      r_wr_ptr        <= '0;
      r_fill          <= '0;
      r_delay_active  <= '0;
      r_delay_pending <= '0;
      r_pend_flag     <= 1'b0;
      r_sel           <= 1'b0;
      r_zero          <= 1'b0;
      r_in_frame      <= '0;
      source_data     <= '0;
      source_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_in_frame <= sink_data;
            r_sel      <= bypass || (r_delay_active == '0);
            // fill counts the frames written before this one
            r_zero     <= ({1'b0, r_delay_active} > r_fill);
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            if (r_fill != FILL_MAX) begin
              r_fill <= r_fill + 1'b1;
            end
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (r_sel) begin
            source_data <= r_in_frame;
          end else if (r_zero) begin
            source_data <= '0;
          end else begin
            source_data <= r_ram_q;
          end
          source_valid <= 1'b1;
          r_state      <= S_OUT;
        end
        S_OUT: begin
          if (source_ready) begin
            source_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A pending delay is applied only between frames. A frame accepted in
      // the same cycle has already sampled the old delay above.
      if ((r_state == S_IDLE) && r_pend_flag) begin
        r_delay_active <= r_delay_pending;
        r_pend_flag    <= 1'b0;
      end
      // A new strobe takes priority, so the last strobe always wins.
      if (predelay_update) begin
        r_delay_pending <= predelay_value;
        r_pend_flag     <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_predelay_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_stream_predelay_mc
//  Purpose  : Scoreboard bench for stream_predelay_mc (2 ch, 24 bit, depth 16)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_predelay_mc;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 4;
  localparam int FW     = NUM_CH * DATA_W;

  logic              clk_clk = 1'b0;
  logic              reset_reset;
  logic [FW-1:0]     sink_data;
  logic              sink_valid;
  logic              sink_ready;
  logic [FW-1:0]     source_data;
  logic              source_valid;
  logic              source_ready;
  logic [ADDR_W-1:0] predelay_value;
  logic              predelay_update;
  logic              bypass;

  stream_predelay_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .sink_data      (sink_data),
    .sink_valid     (sink_valid),
    .sink_ready     (sink_ready),
    .source_data    (source_data),
    .source_valid   (source_valid),
    .source_ready   (source_ready),
    .predelay_value (predelay_value),
    .predelay_update(predelay_update),
    .bypass         (bypass)
  );

  always #5 clk_clk = ~clk_clk;

  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  typedef struct {
    logic [FW-1:0] d;
    bit            lat;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   tests    = 0;
  int   fails    = 0;
  int   last_acc = -1;
  bit   prev_valid = 1'b0;

  function automatic logic [FW-1:0] fr(input int l, input int r);
    return {r[23:0], l[23:0]};
  endfunction

  task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: latency check on the rising edge of valid, data check on transfer
  always @(negedge clk_clk) begin
    exp_t e;
    if (source_valid && !prev_valid && q.size() > 0 && q[0].lat)
      check("latency", FW'(cyc - q[0].acc), FW'(1));
    prev_valid = source_valid;
    if (source_valid && source_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h, expected no frame", source_data);
      end else begin
        e = q.pop_front();
        check("data", source_data, e.d);
      end
    end
  end

  task automatic send(input logic [FW-1:0] din, input logic [FW-1:0] dexp, input bit upd,
                      input logic [ADDR_W-1:0] uval, input bit byp, input int gap, input bit lat);
    exp_t e;
    int   g;
    g = 0;
    while (!sink_ready) begin
      @(posedge clk_clk); #1;
      g++;
      if (g > 50) begin
        tests++;
        fails++;
        $display("FAIL sink_ready_timeout: got 0, expected 1");
        return;
      end
    end
    repeat (gap) begin @(posedge clk_clk); #1; end
    sink_data  = din;
    sink_valid = 1'b1;
    bypass     = byp;
    if (upd) begin
      predelay_value  = uval;
      predelay_update = 1'b1;
    end
    e.d   = dexp;
    e.lat = lat;
    e.acc = cyc + 1;
    q.push_back(e);
    if (lat && last_acc >= 0) check("throughput", FW'(e.acc - last_acc), FW'(3));
    last_acc = e.acc;
    @(posedge clk_clk); #1;
    sink_valid      = 1'b0;
    predelay_update = 1'b0;
    bypass          = 1'b0;
  endtask

  task automatic set_delay(input logic [ADDR_W-1:0] v);
    predelay_value  = v;
    predelay_update = 1'b1;
    @(posedge clk_clk); #1;
    predelay_update = 1'b0;
    @(posedge clk_clk); #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 200) begin
      @(posedge clk_clk); #1;
      g++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d frames outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    #1;
    check("rst_source_valid", FW'(source_valid), FW'(0));
    check("rst_sink_ready", FW'(sink_ready), FW'(0));
    check("rst_source_data", source_data, '0);
    @(posedge clk_clk);
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;
    #1;
    check("rel_sink_ready", FW'(sink_ready), FW'(1));
    @(posedge clk_clk); #1;
    last_acc = -1;
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!source_valid && g < 20) begin
      @(posedge clk_clk); #1;
      g++;
    end
    check("valid_seen", FW'(source_valid), FW'(1));
  endtask

  initial begin
    reset_reset     = 1'b0;
    sink_data       = '0;
    sink_valid      = 1'b0;
    source_ready    = 1'b1;
    predelay_value  = '0;
    predelay_update = 1'b0;
    bypass          = 1'b0;
    @(posedge clk_clk); #1;
    do_reset();

    // Delay 0: stereo frames pass unchanged, 2-edge latency, 1 frame / 3 cycles
    for (int n = 1; n <= 5; n++) send(fr(n, -n), fr(n, -n), 1'b0, '0, 1'b0, 0, 1'b1);
    drain();

    // Backpressure: output must hold while source_ready is low
    source_ready = 1'b0;
    send(fr('hABCD, 'h123456), fr('hABCD, 'h123456), 1'b0, '0, 1'b0, 0, 1'b0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", FW'(source_valid), FW'(1));
      check("bp_data", source_data, fr('hABCD, 'h123456));
      check("bp_sink_ready", FW'(sink_ready), FW'(0));
      @(posedge clk_clk); #1;
    end
    source_ready = 1'b1;
    send(fr(7, 8), fr(7, 8), 1'b0, '0, 1'b0, 0, 1'b0);
    drain();

    // Delay 3 ramp: three zeros, then n-3
    do_reset();
    set_delay(4'd3);
    for (int n = 1; n <= 10; n++)
      send(fr(n, n), (n <= 3) ? '0 : fr(n - 3, n - 3), 1'b0, '0, 1'b0, 0, 1'b0);
    drain();

    // Maximum delay across pointer wrap and fill saturation
    do_reset();
    set_delay(4'd15);
    for (int n = 1; n <= 40; n++)
      send(fr(n, n), (n <= 15) ? '0 : fr(n - 15, n - 15), 1'b0, '0, 1'b0, 0, 1'b0);
    drain();

    // Delay update 2 -> 5 coinciding with frame 20, then bypass on frame 22
    do_reset();
    set_delay(4'd2);
    for (int n = 1; n <= 19; n++)
      send(fr(n, n), (n <= 2) ? '0 : fr(n - 2, n - 2), 1'b0, '0, 1'b0, 0, 1'b0);
    send(fr(20, 20), fr(18, 18), 1'b1, 4'd5, 1'b0, 0, 1'b0);
    send(fr(21, 21), fr(16, 16), 1'b0, '0, 1'b0, 1, 1'b0);
    send(fr(22, 22), fr(22, 22), 1'b0, '0, 1'b1, 0, 1'b0);
    drain();

    // Reset while a frame sits in OUT
    do_reset();
    set_delay(4'd4);
    for (int n = 1; n <= 7; n++)
      send(fr(n, n), (n <= 4) ? '0 : fr(n - 4, n - 4), 1'b0, '0, 1'b0, 0, 1'b0);
    drain();
    source_ready = 1'b0;
    send(fr(8, 8), fr(4, 4), 1'b0, '0, 1'b0, 0, 1'b0);
    wait_valid();
    #2;
    reset_reset = 1'b1;
    #1;
    check("midrst_valid", FW'(source_valid), FW'(0));
    q.delete();
    @(posedge clk_clk);
    @(posedge clk_clk); #1;
    reset_reset  = 1'b0;
    source_ready = 1'b1;
    #1;
    check("midrst_sink_ready", FW'(sink_ready), FW'(1));
    @(posedge clk_clk); #1;
    set_delay(4'd4);
    for (int n = 9; n <= 16; n++)
      send(fr(n, n), (n <= 12) ? '0 : fr(n - 4, n - 4), 1'b0, '0, 1'b0, 0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
